// File: rtl/base_acredit_snk.sv
// base_acredit_snk
//   Receiving end of a credit-based link. The source holds `credits` credits
//   and launches a beat only while it holds one. Because of that, this side
//   never pushes back: every beat goes into a FIFO of depth `credits`. For
//   each beat dequeued downstream, one credit pulse goes back to the source.
//
// Parameters
//   width       data bits per beat
//   credits     FIFO depth; must match the paired source (1..256)
//   log_credits occupancy counter width (derived)
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   i_v, i_d   beat from the link (no ready path)
//   i_r        link-up indication to the source (0 in reset)
//   i_c        credit return pulse, one cycle per dequeued beat
//   o_v, o_d   downstream valid / head-of-FIFO data
//   o_r        downstream ready
//   o_overflow sticky flag: a beat arrived while the FIFO was full
module base_acredit_snk #(
  parameter int width       = 8,
  parameter int credits     = 4,
  parameter int log_credits = $clog2(credits + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v,
  input  logic [width-1:0] i_d,
  output logic             i_r,
  output logic             i_c,
  output logic             o_v,
  input  logic             o_r,
  output logic [width-1:0] o_d,
  output logic             o_overflow
);

  localparam int PTR_W = (credits > 1) ? $clog2(credits) : 1;
  localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(credits - 1);
  localparam logic [log_credits-1:0] OCC_FULL = log_credits'(credits);

  // Pointer advance with an explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) ptr_inc = '0;
    else               ptr_inc = p + PTR_W'(1);
  endfunction

  logic [width-1:0]       mem_q [credits];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [log_credits-1:0] occ_q, occ_d;
  logic                   link_q;
  logic                   crd_q;
  logic                   ovf_q, ovf_d;

  logic full, enq, deq, drop;

  // Fullness is judged on the registered occupancy, i.e. before this
  // cycle's dequeue: a beat arriving into a full FIFO is dropped even if a
  // slot frees up on the same edge.
  assign full = (occ_q == OCC_FULL);
  assign enq  = i_v & ~full;
  assign drop = i_v & full;
  assign o_v  = (occ_q != '0);
  assign deq  = o_v & o_r;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q | drop;
    if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({enq, deq})
      2'b10:   occ_d = occ_q + log_credits'(1);
      2'b01:   occ_d = occ_q - log_credits'(1);
      default: occ_d = occ_q;
    endcase
  end

  // ---- stage 0: control state and credit return flop ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      link_q   <= 1'b0;
      crd_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      link_q   <= 1'b1;
      crd_q    <= deq;
      ovf_q    <= ovf_d;
    end
  end

  // ---- stage 0: storage (data only, not reset) ----
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= i_d;
  end

  // Head data comes straight from the storage flops, so there is no
  // combinational path from i_d and it holds steady while stalled.
  assign o_d        = mem_q[rd_ptr_q];
  assign i_r        = link_q;
  assign i_c        = crd_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_base_acredit_snk.sv
module tb_base_acredit_snk;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_v, o_r;
  logic [7:0] i_d;
  logic       i_r, i_c, o_v, o_overflow;
  logic [7:0] o_d;

  // Second instance for the paired loopback with a behavioural source.
  logic       lb_i_v, lb_o_r;
  logic [7:0] lb_i_d;
  logic       lb_i_r, lb_i_c, lb_o_v, lb_o_overflow;
  logic [7:0] lb_o_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  base_acredit_snk #(.width(8), .credits(4)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_d(i_d), .i_r(i_r), .i_c(i_c),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_overflow(o_overflow)
  );

  base_acredit_snk #(.width(8), .credits(3)) u_lb (
    .clk(clk), .reset(reset), .i_v(lb_i_v), .i_d(lb_i_d), .i_r(lb_i_r),
    .i_c(lb_i_c), .o_v(lb_o_v), .o_r(lb_o_r), .o_d(lb_o_d),
    .o_overflow(lb_o_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, clat, sent, rcvd, cyc;
    logic [7:0] exp_rx;

    reset = 1'b0; i_v = 1'b0; i_d = '0; o_r = 1'b0;
    lb_i_v = 1'b0; lb_i_d = '0; lb_o_r = 1'b0;

    // Reset and link-up
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_i_r", i_r, 0);
      chk("rst_o_v", o_v, 0);
      chk("rst_i_c", i_c, 0);
      chk("rst_ovf", o_overflow, 0);
    end
    reset = 1'b1;
    chk("rel_i_r_pre", i_r, 0);
    step();
    chk("rel_i_r_up", i_r, 1);
    chk("rel_o_v", o_v, 0);

    // Fill with o_r low
    for (int k = 0; k < 4; k++) begin
      i_v = 1'b1; i_d = 8'(8'h11 * (k + 1));
      step();
      chk("fill_o_v", o_v, 1);
      chk("fill_o_d", o_d, 8'h11);
      chk("fill_i_c", i_c, 0);
    end
    i_v = 1'b0;
    step();
    chk("fill_hold_o_d", o_d, 8'h11);
    chk("fill_no_ovf", o_overflow, 0);

    // Drain
    o_r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_o_v", o_v, 1);
      chk("drain_o_d", o_d, 8'(8'h11 * (k + 1)));
      step();
      chk("drain_i_c", i_c, 1);
    end
    chk("drain_empty", o_v, 0);
    step();
    chk("drain_i_c_end", i_c, 0);

    // Streaming across two wraps
    for (int k = 0; k < 10; k++) begin
      i_v = 1'b1; i_d = 8'(k);
      step();
      chk("strm_o_v", o_v, 1);
      chk("strm_o_d", o_d, k);
      chk("strm_i_c", i_c, (k > 0) ? 1 : 0);
    end
    i_v = 1'b0;
    step();
    chk("strm_last_i_c", i_c, 1);
    chk("strm_empty", o_v, 0);
    step();
    chk("strm_i_c_end", i_c, 0);

    // Simultaneous enqueue/dequeue at occupancy 2
    o_r = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_v = 1'b1; i_d = 8'(8'h50 + k);
      step();
    end
    o_r = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("sim_o_d", o_d, 8'h50 + k);
      i_v = 1'b1; i_d = 8'(8'h52 + k);
      step();
      chk("sim_i_c", i_c, 1);
      chk("sim_o_v", o_v, 1);
    end
    i_v = 1'b0;
    for (int k = 5; k < 7; k++) begin
      chk("sim_tail_o_d", o_d, 8'h50 + k);
      step();
      chk("sim_tail_i_c", i_c, 1);
    end
    chk("sim_empty", o_v, 0);
    o_r = 1'b0;
    step();

    // Overflow
    for (int k = 0; k < 4; k++) begin
      i_v = 1'b1; i_d = 8'(8'h61 + k);
      step();
    end
    chk("ovf_pre", o_overflow, 0);
    i_v = 1'b1; i_d = 8'hAA;
    step();
    i_v = 1'b0;
    chk("ovf_set", o_overflow, 1);
    chk("ovf_head", o_d, 8'h61);
    step();
    chk("ovf_sticky", o_overflow, 1);
    o_r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain_o_v", o_v, 1);
      chk("ovf_drain_o_d", o_d, 8'h61 + k);
      step();
    end
    chk("ovf_drain_empty", o_v, 0);
    step();
    chk("ovf_sticky2", o_overflow, 1);
    o_r = 1'b0;

    // Mid-operation reset with 3 beats buffered
    for (int k = 0; k < 3; k++) begin
      i_v = 1'b1; i_d = 8'(8'h71 + k);
      step();
    end
    i_v = 1'b0;
    chk("mrst_pre_o_v", o_v, 1);
    reset = 1'b0;
    #1;
    chk("mrst_o_v", o_v, 0);
    chk("mrst_i_c", i_c, 0);
    chk("mrst_i_r", i_r, 0);
    chk("mrst_ovf", o_overflow, 0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("mrst_link", i_r, 1);
    for (int k = 0; k < 4; k++) begin
      i_v = 1'b1; i_d = 8'(8'h81 + k);
      step();
    end
    i_v = 1'b0;
    chk("mrst_full_ovf", o_overflow, 0);
    o_r = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("mrst_o_d", o_d, 8'h81 + k);
      step();
    end
    chk("mrst_empty", o_v, 0);
    o_r = 1'b0;

    // Paired loopback, credits=3, 30% downstream ready
    cnt = 3; clat = 0; sent = 0; rcvd = 0; cyc = 0; exp_rx = '0;
    while (rcvd < 1000 && cyc < 20000) begin
      cnt  = cnt + clat;
      clat = lb_i_c ? 1 : 0;
      if (lb_i_r && cnt > 0 && sent < 1000) begin
        lb_i_v = 1'b1; lb_i_d = 8'(sent);
        cnt--; sent++;
      end else begin
        lb_i_v = 1'b0;
      end
      lb_o_r = ($urandom_range(0, 9) < 3);
      if (lb_o_v && lb_o_r) begin
        chk("lb_data", lb_o_d, exp_rx);
        exp_rx++;
        rcvd++;
      end
      assert (!lb_o_overflow) else begin
        errors++;
        $error("FAIL lb_overflow: observed %0d expected %0d", lb_o_overflow, 0);
      end
      step();
      cyc++;
    end
    chk("lb_rcvd", rcvd, 1000);
    lb_i_v = 1'b0; lb_o_r = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cnt  = cnt + clat;
      clat = lb_i_c ? 1 : 0;
      step();
    end
    chk("lb_credits_idle", cnt, 3);
    chk("lb_no_ovf", lb_o_overflow, 0);
    chk("lb_empty", lb_o_v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/base_acredit_snk.md
Name: base_acredit_snk

Overview:
- Receiving end of the credit-based link whose source side holds a credit counter and launches a beat only when it holds a credit.
- Accepts one beat per cycle without backpressure into an internal FIFO of depth `credits`.
- Presents the FIFO contents downstream on a valid/ready interface.
- Returns one credit pulse to the source for every beat dequeued downstream.

Parameters:
- width, 8, data bits per beat.
- credits, 4, FIFO depth; must equal the credits parameter of the paired source; legal range 1..256.
- log_credits, $clog2(credits+1), width of the occupancy counter; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk via the existing flop style.
- i_v  input  1  beat valid from the link; no ready path, the source guarantees space through credits.
- i_d  input  width  beat data, qualified by i_v.
- i_r  output  1  link-up indication to the source's o_r; 0 in reset, 1 from the first clock edge after reset release.
- i_c  output  1  credit return pulse to the source's o_c; one cycle high per credit.
- o_v  output  1  downstream valid; high while FIFO non-empty.
- o_r  input  1  downstream ready.
- o_d  output  width  downstream data at FIFO head; registered, no combinational path from i_d.
- o_overflow  output  1  sticky protocol-error flag.

Behaviour:
- Reset (reset=0):
  - write pointer, read pointer and occupancy go to 0.
  - i_r=0, i_c=0, o_v=0, o_overflow=0.
  - o_d is don't-care; storage array is not reset.
  - Reset mid-operation discards all buffered beats. The source resets on the same reset, so credit balance is restored to `credits`.
- Enqueue:
  - i_v=1 and occupancy<credits → write i_d at wr_ptr.
  - wr_ptr increments mod credits: wraps credits-1→0; non-power-of-two depths handled by explicit compare, not bit overflow.
- Dequeue:
  - o_v & o_r → rd_ptr increments mod credits.
- Occupancy:
  - +1 on enqueue only, −1 on dequeue only, unchanged when both occur or neither.
  - Never exceeds credits or drops below 0.
- o_v = (occupancy != 0). o_d = storage[rd_ptr].
- Latency:
  - A beat enqueued at edge N is visible on o_v/o_d in the cycle after edge N: one cycle, no same-cycle bypass.
  - i_c pulses exactly one cycle after each dequeue cycle; registered, one flop.
  - Back-to-back dequeues give back-to-back i_c pulses.
  - Credit round trip to the source is therefore 2 cycles: the i_c flop plus the source's input latch.
- Simultaneous enqueue and dequeue:
  - Legal at any occupancy 1..credits-1.
  - Also legal at occupancy=credits only if the source over-issued, which is overflow (below).
- Overflow:
  - i_v=1 while occupancy==credits, evaluated before that cycle's dequeue: beat dropped, storage and pointers unchanged.
  - o_overflow set the next cycle and held until reset.
  - A dequeue in the same cycle still proceeds and still returns a credit.
- Empty:
  - o_r while o_v=0 has no effect; no pointer move, no i_c.
- o_r may be asserted or withdrawn freely; o_d is held stable while o_v=1 and o_r=0.
- Invariant: occupancy + pending i_c pulses + beats in flight ≤ credits when paired with a conforming source.
- Assertion in bench: o_overflow never rises with a conforming source.

Test Plan:
- Reset/link-up: hold reset=0 for 3 cycles, release → i_r=0 during reset and i_r=1 one edge after release; o_v=0, i_c=0, o_overflow=0 throughout.
- Fill and drain, width=8, credits=4: o_r=0, send 0x11,0x22,0x33,0x44 on consecutive cycles → o_v=1 from the cycle after the first beat, occupancy 4, no i_c. Then o_r=1 for 4 cycles → o_d sequence 0x11..0x44, four consecutive i_c pulses each one cycle after its dequeue, o_v=0 after the last.
- Wrap-around with streaming: o_r=1, send 10 beats 0x00..0x09 back-to-back → output order preserved across two pointer wraps; 10 i_c pulses; occupancy never exceeds 1.
- Simultaneous enq/deq: occupancy 2, i_v=1 with o_r=1 for 5 cycles → occupancy stays 2, i_c high 5 cycles, ordering preserved.
- Overflow: occupancy 4, o_r=0, force i_v=1 d=0xAA → beat dropped, o_overflow=1 next cycle and sticky; subsequent drain yields only the original 4 beats.
- Paired loopback: connect to the source with credits=3, random downstream o_r at 30% → no overflow over 1000 beats, data order intact, source credit count returns to 3 when idle.
- Mid-operation reset: assert reset with 3 beats buffered → o_v=0 and i_c=0 immediately; after release, new beats flow normally with full credit count.
